mb_level_unpacker: RTL

- Downstream consumer of the macroblock result FIFO written by the encode top level.
- Pops one 7-beat, 1024-bit record per macroblock, buffers it, and presents a per-MB header.
- Then streams 4x4 coefficient blocks in coding order (Y2/DC, Y, U, V) over valid/ready to the token/bitstream stage.
- Tracks MB position and signals frame completion.

---
 rtl/mb_level_unpacker.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mb_level_unpacker.sv
// Macroblock result unpacker: pops a 7-beat record from the result FIFO,
// presents the MB header, then streams 4x4 level blocks in coding order.
module mb_level_unpacker #(
  parameter int BEAT_W = 1024,
  parameter int COEF_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        w1,
  input  logic [9:0]        h1,
  input  logic              fifo_empty,
  input  logic [BEAT_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [9:0]        hdr_mb_x,
  output logic [9:0]        hdr_mb_y,
  output logic [7:0]        hdr_mbtype,
  output logic [7:0]        hdr_skipped,
  output logic [31:0]       hdr_mode_i16,
  output logic [127:0]      hdr_mode_i4,
  output logic [31:0]       hdr_mode_uv,
  output logic [31:0]       hdr_nz,
  output logic [31:0]       hdr_max_edge,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [1:0]        coef_type,
  output logic [4:0]        coef_idx,
  output logic              coef_last,
  output logic              fmt_err,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, HDR, COEF, NEXT
  } state_t;

  state_t              state;
  logic [2:0]          beat;
  logic [4*BEAT_W-1:0] ac_q;
  logic [2*BEAT_W-1:0] uv_q;
  logic [COEF_W-1:0]   dc_q;

  logic [1:0]          sel_type;
  logic [4:0]          sel_idx;
  logic [COEF_W-1:0]   sel_data;
  logic                sel_last;
  logic                rsv_bad;
  logic                last_mb;

  assign fifo_rd = (state == LOAD) && !fifo_empty;
  assign last_mb = (hdr_mb_x == w1) && (hdr_mb_y == h1);

  assign rsv_bad = (|fifo_dout[895:480])
                 | (|fifo_dout[927:912])
                 | (|fifo_dout[1023:960]);

  // In HDR pick the first block of the MB, in COEF the successor
  always_comb begin
    sel_type = coef_type;
    sel_idx  = coef_idx + 5'd1;
    if (state == HDR) begin
      sel_type = (hdr_mbtype == 8'd1) ? 2'd0 : 2'd2;
      sel_idx  = 5'd0;
    end else if (coef_type == 2'd0) begin
      sel_type = 2'd1;
      sel_idx  = 5'd0;
    end else if (coef_type != 2'd3 && coef_idx == 5'd15) begin
      sel_type = 2'd3;
      sel_idx  = 5'd0;
    end
    sel_last = (sel_type == 2'd3) && (sel_idx == 5'd7);
    unique case (sel_type)
      2'd0:    sel_data = dc_q;
      2'd3:    sel_data = uv_q[sel_idx[2:0]*COEF_W +: COEF_W];
      default: sel_data = ac_q[sel_idx[3:0]*COEF_W +: COEF_W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      ac_q         <= '0;
      uv_q         <= '0;
      dc_q         <= '0;
      hdr_valid    <= 1'b0;
      hdr_mb_x     <= '0;
      hdr_mb_y     <= '0;
      hdr_mbtype   <= '0;
      hdr_skipped  <= '0;
      hdr_mode_i16 <= '0;
      hdr_mode_i4  <= '0;
      hdr_mode_uv  <= '0;
      hdr_nz       <= '0;
      hdr_max_edge <= '0;
      coef_valid   <= 1'b0;
      coef_data    <= '0;
      coef_type    <= '0;
      coef_idx     <= '0;
      coef_last    <= 1'b0;
      fmt_err      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            beat     <= '0;
            hdr_mb_x <= '0;
            hdr_mb_y <= '0;
            fmt_err  <= 1'b0;
          end
        end
        LOAD: begin
          if (!fifo_empty) begin
            beat <= beat + 3'd1;
            unique case (1'b1)
              !beat[2]: begin
                ac_q[beat[1:0]*BEAT_W +: BEAT_W] <= fifo_dout;
              end
              beat[2:1] == 2'b10: begin
                uv_q[beat[0]*BEAT_W +: BEAT_W] <= fifo_dout;
              end
              default: begin
                dc_q         <= fifo_dout[255:0];
                hdr_mode_i16 <= fifo_dout[287:256];
                hdr_mode_i4  <= fifo_dout[415:288];
                hdr_mode_uv  <= fifo_dout[447:416];
                hdr_nz       <= fifo_dout[479:448];
                hdr_mbtype   <= fifo_dout[903:896];
                hdr_skipped  <= fifo_dout[911:904];
                hdr_max_edge <= fifo_dout[959:928];
                fmt_err      <= fmt_err | rsv_bad;
                hdr_valid    <= 1'b1;
                beat         <= '0;
                state        <= HDR;
              end
            endcase
          end
        end
        HDR: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            if (|hdr_skipped) begin
              state      <= NEXT;
              frame_done <= last_mb;
            end else begin
              state      <= COEF;
              coef_valid <= 1'b1;
              coef_type  <= sel_type;
              coef_idx   <= sel_idx;
              coef_data  <= sel_data;
              coef_last  <= sel_last;
            end
          end
        end
        COEF: begin
          if (coef_ready) begin
            if (coef_last) begin
              coef_valid <= 1'b0;
              coef_last  <= 1'b0;
              state      <= NEXT;
              frame_done <= last_mb;
            end else begin
              coef_type <= sel_type;
              coef_idx  <= sel_idx;
              coef_data <= sel_data;
              coef_last <= sel_last;
            end
          end
        end
        default: begin
          if (last_mb) begin
            state <= IDLE;
          end else if (hdr_mb_x == w1) begin
            hdr_mb_x <= '0;
            hdr_mb_y <= hdr_mb_y + 10'd1;
            state    <= LOAD;
          end else begin
            hdr_mb_x <= hdr_mb_x + 10'd1;
            state    <= LOAD;
          end
        end
      endcase
    end
  end

endmodule
